// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encodings and default widths.
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_RSP = 2'd1,
      DRAIN    = 2'd2
   } fetch_state_t;

   localparam int DEFAULT_ADDR_W  = 32;
   localparam int DEFAULT_INSTR_W = 32;

   // Bits needed to hold an occupancy value in the range 0..depth.
   function automatic int count_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding {pc, instruction} pairs between fetch and decode.
module fetch_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 64,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             push,
   input  logic             pop,
   input  logic             clear,
   input  logic [WIDTH-1:0] push_data,
   output logic [CNT_W-1:0] count,
   output logic [WIDTH-1:0] head
);

   // DEPTH is a power of two, so the pointers wrap by plain overflow.
   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (push && !clear) mem[wr_ptr] <= push_data;
   end

   // Storage is not reset; an empty FIFO presents zeros instead of stale entries.
   assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fetch_buffer.sv
// Fetch stage: issues one instruction-memory request at a time for the current pc and
// queues returned words with their pc for decode; a flush discards wrong-path fetches.
module fetch_buffer
   import fetch_pkg::*;
#(
   parameter int ADDR_W  = DEFAULT_ADDR_W,
   parameter int INSTR_W = DEFAULT_INSTR_W,
   parameter int DEPTH   = 2
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic [ADDR_W-1:0]  pc,
   input  logic               flush,
   output logic               pc_advance,
   output logic               imem_req_valid,
   output logic [ADDR_W-1:0]  imem_req_addr,
   input  logic               imem_req_ready,
   input  logic               imem_rsp_valid,
   input  logic [INSTR_W-1:0] imem_rsp_data,
   output logic               id_valid,
   output logic [INSTR_W-1:0] id_instr,
   output logic [ADDR_W-1:0]  id_pc,
   input  logic               id_ready
);

   localparam int CNT_W   = count_width(DEPTH);
   localparam int ENTRY_W = ADDR_W + INSTR_W;

   fetch_state_t       state;
   logic [ADDR_W-1:0]  pending_pc;
   logic [CNT_W-1:0]   fifo_count;
   logic [CNT_W-1:0]   occ;
   logic [ENTRY_W-1:0] fifo_head;
   logic               issue;
   logic               push;
   logic               pop;

   // The outstanding request reserves a FIFO slot so a response can always be stored.
   assign occ = fifo_count + CNT_W'(state == WAIT_RSP);

   // Held low during reset so neither memory nor the PC module sees a handshake
   // that the FSM is about to forget.
   assign imem_req_valid = reset_n && (state == IDLE) && !flush && (occ < CNT_W'(DEPTH));
   assign imem_req_addr  = pc;
   assign issue          = imem_req_valid && imem_req_ready;
   assign pc_advance     = issue;

   assign push = (state == WAIT_RSP) && imem_rsp_valid && !flush;
   assign pop  = id_valid && id_ready;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state      <= IDLE;
         pending_pc <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (issue) begin
                  pending_pc <= pc;
                  state      <= WAIT_RSP;
               end
            end
            WAIT_RSP: begin
               // A response always closes the request (stored or dropped); a flush
               // without one must swallow the late response in DRAIN.
               if (imem_rsp_valid)  state <= IDLE;
               else if (flush)      state <= DRAIN;
            end
            DRAIN: begin
               if (imem_rsp_valid) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clock     (clock),
      .reset_n   (reset_n),
      .push      (push),
      .pop       (pop),
      .clear     (flush),
      .push_data ({pending_pc, imem_rsp_data}),
      .count     (fifo_count),
      .head      (fifo_head)
   );

   assign id_valid          = (fifo_count != '0);
   assign {id_pc, id_instr} = fifo_head;

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer: inputs change at the falling edge, outputs are checked 1 time unit later.
module tb_fetch_buffer;

   logic        clock;
   logic        reset_n;
   logic [31:0] pc;
   logic        flush;
   logic        pc_advance;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        id_valid;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
   logic        id_ready;

   int          checks = 0;
   int          errors = 0;
   bit          auto_mem = 0;
   logic        acc_q = 0;
   logic [31:0] acc_addr = '0;

   fetch_buffer #(.ADDR_W(32), .INSTR_W(32), .DEPTH(2)) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .pc             (pc),
      .flush          (flush),
      .pc_advance     (pc_advance),
      .imem_req_valid (imem_req_valid),
      .imem_req_addr  (imem_req_addr),
      .imem_req_ready (imem_req_ready),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .id_valid       (id_valid),
      .id_instr       (id_instr),
      .id_pc          (id_pc),
      .id_ready       (id_ready)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // One clock cycle of stimulus. With auto_mem set, a 1-cycle memory answers the
   // request accepted in the previous cycle with 0x1000_0000 | addr.
   task automatic cyc(input logic rn, input logic [31:0] p, input logic rdy, input logic idr,
                      input logic fl, input logic rv, input logic [31:0] rd);
      @(negedge clock);
      reset_n        = rn;
      pc             = p;
      imem_req_ready = rdy;
      id_ready       = idr;
      flush          = fl;
      if (auto_mem) begin
         imem_rsp_valid = acc_q;
         imem_rsp_data  = 32'h1000_0000 | acc_addr;
      end else begin
         imem_rsp_valid = rv;
         imem_rsp_data  = rd;
      end
      #1;
      acc_q    = imem_req_valid && imem_req_ready;
      acc_addr = imem_req_addr;
   endtask

   task automatic do_reset();
      auto_mem = 0;
      cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
   endtask

   task automatic test_reset();
      auto_mem = 0;
      cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid: got %0b want 0", imem_req_valid); end
      checks++; if (pc_advance !== 1'b0) begin errors++; $display("FAIL rst_pc_advance: got %0b want 0", pc_advance); end
      checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rst_id_valid: got %0b want 0", id_valid); end
      checks++; if (id_instr !== 32'h0) begin errors++; $display("FAIL rst_id_instr: got %h want 0", id_instr); end
      checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL rst_id_pc: got %h want 0", id_pc); end
   endtask

   task automatic test_straight_line();
      logic [31:0] sl_pc  [7];
      logic        sl_adv [7];
      logic        sl_idv [7];
      logic [31:0] sl_ipc [7];
      sl_pc  = '{32'd0, 32'd4, 32'd4, 32'd8, 32'd8, 32'd12, 32'd12};
      sl_adv = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      sl_idv = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      sl_ipc = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd4, 32'd0, 32'd8};
      auto_mem = 1;
      for (int c = 1; c <= 7; c++) begin
         cyc(1'b1, sl_pc[c-1], 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
         checks++; if (pc_advance !== sl_adv[c-1]) begin errors++; $display("FAIL sl_pc_advance c%0d: got %0b want %0b", c, pc_advance, sl_adv[c-1]); end
         checks++; if (id_valid !== sl_idv[c-1]) begin errors++; $display("FAIL sl_id_valid c%0d: got %0b want %0b", c, id_valid, sl_idv[c-1]); end
         if (sl_idv[c-1]) begin
            checks++; if (id_pc !== sl_ipc[c-1]) begin errors++; $display("FAIL sl_id_pc c%0d: got %h want %h", c, id_pc, sl_ipc[c-1]); end
            checks++; if (id_instr !== (32'h1000_0000 | sl_ipc[c-1])) begin errors++; $display("FAIL sl_id_instr c%0d: got %h want %h", c, id_instr, 32'h1000_0000 | sl_ipc[c-1]); end
         end
      end
      auto_mem = 0;
   endtask

   task automatic test_backpressure();
      logic [31:0] bp_pc  [13];
      logic        bp_idr [13];
      logic        bp_fl  [13];
      logic        bp_req [13];
      int          issued;
      bp_pc  = '{32'h100, 32'h104, 32'h104, 32'h108, 32'h108, 32'h108, 32'h108,
                 32'h108, 32'h108, 32'h10C, 32'h10C, 32'h200, 32'h200};
      bp_idr = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      bp_fl  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      bp_req = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      issued = 0;
      do_reset();
      auto_mem = 1;
      for (int c = 1; c <= 13; c++) begin
         cyc(1'b1, bp_pc[c-1], 1'b1, bp_idr[c-1], bp_fl[c-1], 1'b0, 32'h0);
         if (c <= 12 && pc_advance) issued++;
         checks++; if (imem_req_valid !== bp_req[c-1]) begin errors++; $display("FAIL bp_req_valid c%0d: got %0b want %0b", c, imem_req_valid, bp_req[c-1]); end
         if (c == 5 || c == 8) begin
            checks++; if (id_pc !== 32'h100) begin errors++; $display("FAIL bp_head_pc c%0d: got %h want 100", c, id_pc); end
         end
         if (c == 9 || c == 11) begin
            checks++; if (id_pc !== 32'h104) begin errors++; $display("FAIL bp_head_after_pop c%0d: got %h want 104", c, id_pc); end
         end
         if (c == 12) begin
            checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL bp_full_before_flush: got %0b want 1", id_valid); end
         end
         if (c == 13) begin
            checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL bp_flush_clears: got %0b want 0", id_valid); end
            checks++; if (imem_req_addr !== 32'h200) begin errors++; $display("FAIL bp_redirect_addr: got %h want 200", imem_req_addr); end
         end
      end
      checks++; if (issued != 3) begin errors++; $display("FAIL bp_issue_count: got %0d want 3", issued); end
      auto_mem = 0;
   endtask

   task automatic test_flush_no_rsp();
      do_reset();
      cyc(1'b1, 32'h20, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      checks++; if (pc_advance !== 1'b1) begin errors++; $display("FAIL fn_issue: got %0b want 1", pc_advance); end
      cyc(1'b1, 32'd12, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL fn_req_during_flush: got %0b want 0", imem_req_valid); end
      cyc(1'b1, 32'd12, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_DEAD);
      checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL fn_req_in_drain: got %0b want 0", imem_req_valid); end
      cyc(1'b1, 32'd12, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL fn_dead_dropped: got %0b want 0", id_valid); end
      checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'd12) begin errors++; $display("FAIL fn_refetch: got valid %0b addr %h want 1 0000000c", imem_req_valid, imem_req_addr); end
      cyc(1'b1, 32'd16, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_1234);
      cyc(1'b1, 32'd16, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      checks++; if (id_valid !== 1'b1 || id_pc !== 32'd12 || id_instr !== 32'h1234) begin errors++; $display("FAIL fn_new_entry: got v%0b pc %h instr %h want 1 0000000c 00001234", id_valid, id_pc, id_instr); end
   endtask

   task automatic test_flush_with_rsp();
      do_reset();
      cyc(1'b1, 32'h30, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      cyc(1'b1, 32'h50, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_BEEF);
      checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL fr_req_during_flush: got %0b want 0", imem_req_valid); end
      cyc(1'b1, 32'h50, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL fr_rsp_dropped: got %0b want 0", id_valid); end
      checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h50) begin errors++; $display("FAIL fr_back_to_idle: got valid %0b addr %h want 1 00000050", imem_req_valid, imem_req_addr); end
      cyc(1'b1, 32'h50, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL fr_id_valid_stays: got %0b want 0", id_valid); end
   endtask

   task automatic test_mem_stall();
      do_reset();
      for (int c = 1; c <= 3; c++) begin
         cyc(1'b1, 32'h60, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
         checks++; if (pc_advance !== 1'b0) begin errors++; $display("FAIL ms_pc_advance c%0d: got %0b want 0", c, pc_advance); end
         checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h60) begin errors++; $display("FAIL ms_req_held c%0d: got valid %0b addr %h want 1 00000060", c, imem_req_valid, imem_req_addr); end
      end
      cyc(1'b1, 32'h60, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      checks++; if (pc_advance !== 1'b1) begin errors++; $display("FAIL ms_handshake: got %0b want 1", pc_advance); end
      cyc(1'b1, 32'h64, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_600D);
      cyc(1'b1, 32'h64, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      checks++; if (id_valid !== 1'b1 || id_pc !== 32'h60 || id_instr !== 32'h600D) begin errors++; $display("FAIL ms_entry: got v%0b pc %h instr %h want 1 00000060 0000600d", id_valid, id_pc, id_instr); end
   endtask

   task automatic test_reset_in_wait();
      do_reset();
      cyc(1'b1, 32'h70, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      cyc(1'b0, 32'h74, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      cyc(1'b1, 32'h74, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0BAD);
      checks++; if (imem_req_valid !== 1'b1 || pc_advance !== 1'b0) begin errors++; $display("FAIL rw_idle_after_reset: got valid %0b adv %0b want 1 0", imem_req_valid, pc_advance); end
      cyc(1'b1, 32'h74, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rw_late_rsp_ignored: got %0b want 0", id_valid); end
      checks++; if (pc_advance !== 1'b1 || imem_req_addr !== 32'h74) begin errors++; $display("FAIL rw_first_req: got adv %0b addr %h want 1 00000074", pc_advance, imem_req_addr); end
      cyc(1'b1, 32'h78, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_7777);
      cyc(1'b1, 32'h78, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      checks++; if (id_valid !== 1'b1 || id_pc !== 32'h74 || id_instr !== 32'h7777) begin errors++; $display("FAIL rw_entry: got v%0b pc %h instr %h want 1 00000074 00007777", id_valid, id_pc, id_instr); end
   endtask

   initial begin
      reset_n        = 1'b0;
      pc             = '0;
      flush          = 1'b0;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      id_ready       = 1'b0;
      test_reset();
      test_straight_line();
      test_backpressure();
      test_flush_no_rsp();
      test_flush_with_rsp();
      test_mem_stall();
      test_reset_in_wait();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
